fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory and feeds decode. It owns the PC and drives the word-aligned fetch address to the combinational instruction memory. It captures the returned 32-bit instruction word together with its PC in a small prefetch FIFO and presents it to decode over a valid/ready handshake. Decode or execute can redirect fetch on a taken branch, which flushes the FIFO.

Parameters:
- ADDR_W, 32, width of the PC and fetch address.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- FIFO_DEPTH, 2, prefetch entries; a power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  ADDR_W  fetch address to instruction memory; equals the internal PC.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- br_taken  in  1  redirect request; single-cycle pulse.
- br_target  in  ADDR_W  redirect address; bits [1:0] ignored.
- if_valid  out  1  FIFO head holds an instruction.
- if_instr  out  32  instruction at FIFO head.
- if_pc  out  ADDR_W  PC of the FIFO head instruction.
- id_ready  in  1  decode accepts the head this cycle.
- stall_cnt  out  32  back-pressure counter; see Optional Feature.

Behaviour:
- Reset (reset==0 at posedge clk): pc<=RESET_PC, FIFO pointers and count<=0, if_valid=0, if_instr=0, if_pc=0, stall_cnt<=0. Reset has priority over all other inputs, including mid-redirect and a full FIFO.
- imem_addr = pc, continuously (combinational from the register).
- pop = if_valid & id_ready.
- push = !br_taken & (count<FIFO_DEPTH | pop). When push is asserted, {pc, imem_rdata} is written at the tail and pc<=pc+4.
- pc+4 wraps modulo 2^ADDR_W; 0xFFFF_FFFC is followed by 0x0000_0000.
- Full with no pop: no push, pc holds, imem_addr stable.
- Push and pop in the same cycle: count unchanged. A full FIFO with pop still pushes.
- Redirect (br_taken==1, reset inactive):
  - FIFO count and pointers clear.
  - pc<={br_target[ADDR_W-1:2],2'b00}.
  - No push that cycle.
  - If pop is also asserted that cycle, the handshake completes normally: decode has taken the head.
  - Next cycle: if_valid=0 and imem_addr=target. The cycle after: if_valid=1 with the target instruction.
- Latency:
  - First cycle after reset release: push of RESET_PC. if_valid=1 the following cycle.
  - Steady state: one instruction per cycle with id_ready held high.
- Outputs when empty: if_valid=0. if_instr and if_pc are don't-care but must not be X. They are driven from the head storage.
- FIFO: circular buffer, log2(FIFO_DEPTH)-bit pointers that wrap naturally, and a count register of width log2(FIFO_DEPTH)+1.
- State: EMPTY (count==0), PARTIAL, FULL (count==FIFO_DEPTH). Transitions follow push/pop/flush as above. Flush goes to EMPTY from any state.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 every cycle with if_valid & !id_ready, saturating at 32'hFFFF_FFFF. It is cleared only by reset.
- Undefined: no counter logic is built; stall_cnt is tied to 0.

Decomposition:
- fetch_pkg holds:
  - INSTR_W=32 and PC_INC=4.
  - DEFAULT_RESET_PC.
  - Typedef fetch_entry_t {pc, instr}.
- A natural sub-module is fetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and head outputs. fetch_unit holds the PC logic, handshake and counter.

Test Plan:
- Reset release, memory words 0x00940333 at 0 and 0x413903b3 at 4, id_ready=1 -> cycle 2 if_valid=1, if_pc=0, if_instr=0x00940333; cycle 3 if_pc=4, if_instr=0x413903b3.
- id_ready=0 for 5 cycles after reset -> FIFO fills with PC 0 and 4, imem_addr holds 8, if_pc stays 0; with macro defined stall_cnt=4 after the window. Release id_ready -> PCs 0, 4, 8 in consecutive cycles with no gap.
- br_taken=1, br_target=0x0000_0016 while FIFO holds 2 entries -> next cycle if_valid=0 and imem_addr=0x14; following cycle if_pc=0x14; no stale PC (8 or 0xC) ever presented.
- br_taken and pop in the same cycle -> head counted consumed once; no duplicate after flush.
- RESET_PC=0xFFFF_FFF8, id_ready=1 -> if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset asserted while FIFO is full and br_taken=1 -> next cycle if_valid=0, imem_addr=RESET_PC, stall_cnt=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Occupancy of the prefetch FIFO
  typedef enum logic [1:0] {
    FQ_EMPTY,
    FQ_PARTIAL,
    FQ_FULL
  } fifo_state_e;

  // One prefetched instruction with the PC it was fetched from (32-bit PC build)
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: circular buffer of fetch entries with push/pop/flush.
// Occupancy is tracked by a count register plus an EMPTY/PARTIAL/FULL state.
// The caller never pushes when full without a pop, never pops when empty,
// and never pushes during a flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wr_data,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  fifo_state_e        state_q, state_d;

  // Entry storage; cleared only on reset so the head is never X, even after a flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  // Read/write pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Next occupancy: flush wins, simultaneous push+pop leaves count unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State register (count and occupancy state)
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= FQ_EMPTY;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Next-state: derived from the next occupancy, flush always lands in EMPTY
  always_comb begin
    state_d = FQ_PARTIAL;
    if (flush || cnt_d == '0) state_d = FQ_EMPTY;
    else if (cnt_d == CNT_FULL) state_d = FQ_FULL;
  end

  // Outputs decoded from the registered state
  always_comb begin
    full  = (state_q == FQ_FULL);
    empty = (state_q == FQ_EMPTY);
  end

  assign head = mem_q[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory, buffers {pc, instr} in a prefetch FIFO and hands it to decode over
// valid/ready. A taken branch redirects the PC and flushes the FIFO.
// Optional: define FETCH_STALL_CNT_EN to build the saturating back-pressure
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  output logic [31:0]        stall_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic              push, pop, fifo_full, fifo_empty;
  entry_t            wr_entry, head;
  logic              unused_br_lsb;

  assign unused_br_lsb = ^br_target[1:0];

  assign imem_addr = pc_q;
  assign if_valid  = !fifo_empty;
  assign pop       = if_valid & id_ready;
  // A full FIFO can still accept when the head leaves this cycle
  assign push      = !br_taken & (!fifo_full | pop);
  assign wr_entry  = '{pc: pc_q, instr: imem_rdata};
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;

  // PC: redirect beats sequential advance; advance only when the fetch was captured
  always_ff @(posedge clk) begin
    if (!reset)        pc_q <= RESET_PC;
    else if (br_taken) pc_q <= {br_target[ADDR_W-1:2], 2'b00};
    else if (push)     pc_q <= pc_q + ADDR_W'(PC_INC);
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (br_taken),
    .wr_data (wr_entry),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where decode holds off a valid head; saturate, clear on reset only
  always_ff @(posedge clk) begin
    if (!reset)                                      stall_q <= '0;
    else if (if_valid && !id_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected PCs, compared on
// each decode handshake, plus point checks for reset, latency, stall and redirect.
// A second instance starts near the top of the address space to cover PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata, br_target, if_instr, if_pc, stall_cnt;
  logic        br_taken, if_valid, id_ready;

  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_stall, w_target;
  logic        w_valid, w_ready, w_br;

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] q[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  // Instruction memory model
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0094_0333;
    if (a == 32'h4) return 32'h4139_03b3;
    return (a * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign w_rdata    = mem(w_addr);

  fetch_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .stall_cnt  (stall_cnt)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (w_addr),
    .imem_rdata (w_rdata),
    .br_taken   (w_br),
    .br_target  (w_target),
    .if_valid   (w_valid),
    .if_instr   (w_instr),
    .if_pc      (w_pc),
    .id_ready   (w_ready),
    .stall_cnt  (w_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit which, input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) q2.push_back(start + 32'(4 * i));
      else       q.push_back(start + 32'(4 * i));
    end
  endtask

  // One clock: score handshakes at the negedge, then advance past the posedge
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (reset) begin
      if (if_valid && id_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        chk("sb_pc", if_pc, e);
        chk("sb_instr", if_instr, mem(e));
      end
      if (w_valid && w_ready) begin
        e = (q2.size() > 0) ? q2.pop_front() : 32'hDEAD_BEEF;
        chk("sb_wrap_pc", w_pc, e);
        chk("sb_wrap_instr", w_instr, mem(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    id_ready  = 1'b1;
    w_ready   = 1'b1;
    w_br      = 1'b0;
    w_target  = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

    // Release with decode ready: first valid one cycle after release
    fill(0, 32'h0, 32);
    fill(1, 32'hFFFF_FFF8, 64);
    reset = 1'b1;
    tick();
    chk("lat_valid", 32'(if_valid), 32'd1);
    chk("lat_pc", if_pc, 32'h0);
    chk("lat_instr", if_instr, 32'h0094_0333);
    tick();
    chk("seq_pc1", if_pc, 32'h4);
    chk("seq_instr1", if_instr, 32'h4139_03b3);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2", w_pc, 32'h0);
    repeat (3) tick();

    // Back-pressure right after reset: FIFO fills with 0 and 4, PC parks at 8
    reset = 1'b0;
    tick();
    q.delete();
    q2.delete();
    fill(0, 32'h0, 32);
    fill(1, 32'hFFFF_FFF8, 64);
    id_ready = 1'b0;
    reset    = 1'b1;
    repeat (5) tick();
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", if_pc, 32'h0);
    chk("stall_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd4);
`else
    chk("stall_cnt_off", stall_cnt, 32'd0);
`endif
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nogap_valid", 32'(if_valid), 32'd1);
    end

    // Redirect while FIFO is full: bubble, then target, never stale PCs
    id_ready = 1'b0;
    repeat (3) tick();
    br_taken  = 1'b1;
    br_target = 32'h0000_0016;
    tick();
    br_taken = 1'b0;
    q.delete();
    fill(0, 32'h14, 32);
    chk("br_valid", 32'(if_valid), 32'd0);
    chk("br_addr", imem_addr, 32'h14);
    id_ready = 1'b1;
    tick();
    chk("br_pc", if_pc, 32'h14);
    chk("br_instr", if_instr, mem(32'h14));
    repeat (3) tick();

    // Redirect together with a pop: head consumed once, no duplicate afterwards
    br_taken  = 1'b1;
    br_target = 32'h0000_0100;
    tick();
    br_taken = 1'b0;
    q.delete();
    fill(0, 32'h100, 32);
    chk("brpop_valid", 32'(if_valid), 32'd0);
    chk("brpop_addr", imem_addr, 32'h100);
    repeat (4) tick();
    chk("brpop_pc", if_pc, 32'h10C);

    // Reset beats a redirect on a full FIFO
    id_ready = 1'b0;
    repeat (3) tick();
    reset     = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h0000_0040;
    tick();
    br_taken = 1'b0;
    chk("rstbr_valid", 32'(if_valid), 32'd0);
    chk("rstbr_addr", imem_addr, 32'h0);
    chk("rstbr_stall", stall_cnt, 32'h0);
    chk("rstbr_wrap_addr", w_addr, 32'hFFFF_FFF8);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
